// File: rtl/ekf_stage_sched.sv
// ekf_stage_sched
//   Sequences the EKF-SLAM systolic array through its PRD / NEW / UPD stages.
//   Odometry (predict) requests take priority over observations; observations
//   are held off until one predict has completed since reset. Each accepted
//   observation is classified as NEW (next free landmark slot) or UPD (known
//   landmark) and issued to the array as a one-hot stage request. Bad
//   observation indices and array start timeouts raise a one-cycle err pulse.
//
// Ports
//   clk           rising-edge clock
//   sys_rst       asynchronous reset, active low
//   odo_val/rdy   predict request handshake
//   obs_val/rdy   observation request handshake, obs_id = landmark index
//   stage_val     one-hot stage request to the array (001 PRD, 010 NEW, 100 UPD)
//   stage_rdy     per-stage array status, high = idle, low = executing
//   landmark_num  current landmark count
//   l_k           landmark index of the current / last NEW or UPD stage
//   busy          scheduler not idle
//   err           one-cycle pulse on rejected observation or start timeout
module ekf_stage_sched #(
  parameter int unsigned ROW_LEN = 10,
  parameter int unsigned MAX_LM  = 500,
  parameter int unsigned TO_CYC  = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               odo_val,
  output logic               odo_rdy,
  input  logic               obs_val,
  input  logic [ROW_LEN-1:0] obs_id,
  output logic               obs_rdy,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_COMMIT
  } state_e;

  typedef enum logic [2:0] {
    STG_NONE = 3'b000,
    STG_PRD  = 3'b001,
    STG_NEW  = 3'b010,
    STG_UPD  = 3'b100
  } stage_e;

  localparam logic [ROW_LEN-1:0] MAX_LM_V = ROW_LEN'(MAX_LM);
  localparam logic [TO_W-1:0]    TO_LIM   = TO_W'(TO_CYC);

  state_e             state_q, state_d;
  stage_e             stage_q, stage_d;
  logic [ROW_LEN-1:0] lm_q, lm_d;
  logic [ROW_LEN-1:0] lk_q, lk_d;
  logic               prd_seen_q, prd_seen_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;
  logic               stage_hit;

  // State register
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= S_IDLE;
      stage_q    <= STG_NONE;
      lm_q       <= '0;
      lk_q       <= '0;
      prd_seen_q <= 1'b0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      lm_q       <= lm_d;
      lk_q       <= lk_d;
      prd_seen_q <= prd_seen_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  // Latched stage bit as seen on the array status bus
  assign stage_hit = |(stage_q & stage_rdy);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    lm_d       = lm_q;
    lk_d       = lk_q;
    prd_seen_d = prd_seen_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (odo_val && rdy_q) begin
          stage_d = STG_PRD;
          state_d = S_ISSUE;
        end else if (obs_val && rdy_q && prd_seen_q) begin
          if (obs_id < lm_q) begin
            stage_d = STG_UPD;
            lk_d    = obs_id;
            state_d = S_ISSUE;
          end else if ((obs_id == lm_q) && (lm_q < MAX_LM_V)) begin
            stage_d = STG_NEW;
            lk_d    = obs_id;
            state_d = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (stage_hit) begin
          state_d  = S_WAIT_START;
          to_cnt_d = '0;
        end
      end
      S_WAIT_START: begin
        if (!stage_hit) begin
          state_d  = S_WAIT_DONE;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // Array never started: abandon the stage without committing it
          if (to_cnt_d == TO_LIM) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            to_cnt_d = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        if (stage_hit) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        case (stage_q)
          STG_PRD: prd_seen_d = 1'b1;
          STG_NEW: if (lm_q < MAX_LM_V) lm_d = lm_q + 1'b1;
          default: ;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready flags are registered so they stay low while reset is held
    rdy_d = (state_d == S_IDLE);
  end

  // Outputs
  always_comb begin
    odo_rdy      = rdy_q;
    obs_rdy      = rdy_q & prd_seen_q & ~odo_val;
    stage_val    = (state_q == S_ISSUE) ? stage_q : STG_NONE;
    busy         = (state_q != S_IDLE);
    err          = err_q;
    landmark_num = lm_q;
    l_k          = lk_q;
  end

endmodule
